ram_stream_reader: RTL and testbench
====================================

Name: ram_stream_reader

Overview:
- Read-side master for the simple dual-port RAM (registered read, 1-cycle latency, no read enable) in the display/board-memory path.
- On a start command, walks a contiguous address range and turns RAM words into a valid/ready stream with last marker.
- Absorbs RAM latency and downstream backpressure internally.
- Runs on the RAM read clock only.

Parameters:
- DATA_WIDTH, 7, RAM word width.
- ADDR_WIDTH, 9, RAM address width; address space 2**ADDR_WIDTH words.
- BUF_DEPTH, 4, output buffer entries; must be ≥ 3 for full rate (localparam check).

Ports:
- clock_i  input  1  read clock; also drives RAM read_clock_i.
- reset_i  input  1  asynchronous, active-high reset.
- start_i  input  1  begin transfer; sampled only in IDLE.
- base_addr_i  input  ADDR_WIDTH  first address; captured with start_i.
- length_i  input  ADDR_WIDTH+1  word count 0..2**ADDR_WIDTH; captured with start_i.
- read_addr_o  output  ADDR_WIDTH  to RAM read_addr_i; registered.
- ram_q_i  input  DATA_WIDTH  from RAM q_o.
- data_o  output  DATA_WIDTH  stream data.
- valid_o  output  1  stream valid.
- ready_i  input  1  stream ready; beat transfers when valid_o && ready_i.
- last_o  output  1  high with the final beat only.
- busy_o  output  1  high outside IDLE.
- done_o  output  1  one-cycle pulse at transfer end.

Behaviour:
- Reset (async, immediate): state IDLE; read_addr_o=0, valid_o=0, last_o=0, data_o=0, busy_o=0, done_o=0; buffer, counters and in-flight pipe cleared.
- FSM states: IDLE, RUN, FINISH.
  - IDLE: start_i=1 captures base/length and goes to RUN, or to FINISH if length_i=0.
  - RUN: goes to FINISH on the edge that accepts the last beat.
  - FINISH: done_o=1 for exactly one cycle, then IDLE.
  - start_i outside IDLE is ignored, with no effect on the current transfer.
- Issue:
  - A read is issued in a RUN cycle when issued < length and buf_count + inflight − pop < BUF_DEPTH. pop = valid_o && ready_i in that cycle.
  - On issue, read_addr_o advances to the next address at the clock edge.
  - Address increments modulo 2**ADDR_WIDTH, so base 510, length 4 reads 510, 511, 0, 1.
- Latency tracking:
  - A 2-stage valid shift register marks the cycle in which ram_q_i holds the word for an issued address (the RAM has no enable, so q changes every cycle).
  - The word is pushed into the buffer at the edge ending that cycle.
  - First valid_o is high 3 edges after the edge that samples start_i, with ready_i=1 throughout.
- Throughput: with ready_i held high, one beat per cycle with no bubbles after the first.
- Buffer: FIFO of BUF_DEPTH entries; data_o/valid_o come from the head.
  - Push and pop in the same cycle keep the count unchanged.
  - The credit rule guarantees no overflow; overflow is an assertion failure.
- Stream stability: while valid_o=1 and ready_i=0, data_o and last_o hold.
- last_o: tagged on the word whose issue index = length−1; asserted only with that beat.
- done_o:
  - Rises the cycle after the last beat is accepted.
  - For length 0, rises the cycle after start; no beats and no reads issued.
- busy_o: 1 in RUN and FINISH.
- Width: counters are ADDR_WIDTH+1 bits; length 2**ADDR_WIDTH reads the whole RAM exactly once.
- Reset mid-transfer: all in-flight words are discarded and valid_o drops immediately.

Decomposition:
- Shared package holds:
  - The FSM state enum (IDLE/RUN/FINISH).
  - Defaults for DATA_WIDTH/ADDR_WIDTH, shared with simple_dual_port_ram_dual_clock instances.
- One sub-module: stream_fifo (BUF_DEPTH × DATA_WIDTH+1 bits including the last tag), with push/pop/count and async active-high reset.

Test Plan:
- RAM preloaded with ram[a]=a mod 128; start, base=0, length=5, ready_i=1 -> beats 0,1,2,3,4 on consecutive cycles; first valid_o 3 edges after start; last_o only on 4; done_o one pulse on the next cycle.
- base=510, length=4 -> data 126,127,0,1 (addresses 510,511,0,1); read_addr_o wraps to 0.
- length=3, ready_i low for 6 cycles after the first valid -> data_o=0 held stable; no overflow; after release, 0,1,2 delivered in order with none lost or duplicated.
- length=0 -> done_o pulses 1 cycle after start; valid_o never asserts; busy_o high for exactly 1 cycle.
- start_i re-pulsed mid-transfer with base=100 -> ignored; original sequence completes unchanged.
- reset_i asserted asynchronously mid-transfer (between clock edges) -> valid_o, busy_o, read_addr_o go to 0 before the next edge; a fresh start, base=7, length=2 then yields 7,8 correctly.

Source files
------------

// File: rtl/ram_stream_reader_pkg.sv
// Shared types and default geometry for the RAM stream reader and the
// simple_dual_port_ram_dual_clock instances it reads from.
package ram_stream_reader_pkg;

  localparam int DEFAULT_DATA_WIDTH = 7;
  localparam int DEFAULT_ADDR_WIDTH = 9;
  localparam int DEFAULT_BUF_DEPTH  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/ram_stream_reader_fifo.sv
// Small output FIFO for the stream reader; entries carry the word plus its
// last tag. Head is presented combinationally from storage.
module stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clock_i,
  input  logic                       reset_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_data_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop      = pop_i && (count != '0);
  assign empty_o     = (count == '0);
  assign count_o     = count;
  assign head_data_o = mem[rd_ptr];

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_i) begin
        mem[wr_ptr] <= push_data_i;
        wr_ptr      <= bump(wr_ptr);
      end
      if (do_pop) rd_ptr <= bump(rd_ptr);
      if (push_i && !do_pop)      count <= count + 1'b1;
      else if (!push_i && do_pop) count <= count - 1'b1;
    end
  end

  // The reader's credit scheme must never push into a full buffer.
  always @(posedge clock_i)
    if (!reset_i && push_i && !do_pop) assert (count < CW'(DEPTH));

endmodule

// File: rtl/ram_stream_reader.sv
// Walks a contiguous RAM address range (wrapping) and turns the registered
// RAM read data into a valid/ready stream with a last marker.
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int BUF_DEPTH  = DEFAULT_BUF_DEPTH
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH:0]   length_i,
  output logic [ADDR_WIDTH-1:0] read_addr_o,
  input  logic [DATA_WIDTH-1:0] ram_q_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  last_o,
  output logic                  busy_o,
  output logic                  done_o,
  output state_t                state_o
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam int NW = $clog2(BUF_DEPTH + 1);
  localparam int OW = NW + 2;

  if (BUF_DEPTH < 3) begin : g_depth_check
    $error("BUF_DEPTH must be at least 3 for full-rate streaming");
  end

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [CW-1:0]         length_q;
  logic [CW-1:0]         issued;
  logic [1:0]            pipe_vld;
  logic [1:0]            pipe_last;
  logic [NW-1:0]         buf_count;
  logic [OW-1:0]         credit_used;
  logic [DATA_WIDTH:0]   head_entry;
  logic                  buf_empty;
  logic                  issue;
  logic                  pop;

  // Stream handshake: a beat transfers on the rising edge where valid_o and
  // ready_i are both high; once valid_o rises, data_o/last_o hold until then.
  assign valid_o = !buf_empty;
  assign pop     = valid_o && ready_i;
  assign data_o  = buf_empty ? '0 : head_entry[DATA_WIDTH-1:0];
  assign last_o  = !buf_empty && head_entry[DATA_WIDTH];
  assign busy_o  = (state != ST_IDLE);
  assign done_o  = (state == ST_FINISH);
  assign state_o = state;

  // Words already in flight hold a buffer slot, so the buffer cannot overflow.
  assign credit_used = OW'(buf_count) + OW'(pipe_vld[0]) + OW'(pipe_vld[1]) - OW'(pop);
  assign issue = (state == ST_RUN) && (issued < length_q) && (credit_used < OW'(BUF_DEPTH));

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (start_i) state_nx = (length_i == '0) ? ST_FINISH : ST_RUN;
      ST_RUN:    if (pop && last_o) state_nx = ST_FINISH;
      ST_FINISH: state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) state <= ST_IDLE;
    else         state <= state_nx;
  end

  // read_addr_o takes the issued address; the RAM samples it one edge later
  // and q holds the word during the cycle flagged by pipe_vld[1].
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      read_addr_o <= '0;
      next_addr   <= '0;
      length_q    <= '0;
      issued      <= '0;
      pipe_vld    <= '0;
      pipe_last   <= '0;
    end else begin
      if (state == ST_IDLE && start_i) begin
        next_addr <= base_addr_i;
        length_q  <= length_i;
        issued    <= '0;
      end
      if (issue) begin
        read_addr_o <= next_addr;
        next_addr   <= next_addr + 1'b1;
        issued      <= issued + 1'b1;
      end
      pipe_vld  <= {pipe_vld[0], issue};
      pipe_last <= {pipe_last[0], issue && (issued == length_q - 1'b1)};
    end
  end

  stream_fifo #(
    .WIDTH(DATA_WIDTH + 1),
    .DEPTH(BUF_DEPTH)
  ) u_fifo (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .push_i      (pipe_vld[1]),
    .push_data_i ({pipe_last[1], ram_q_i}),
    .pop_i       (pop),
    .head_data_o (head_entry),
    .empty_o     (buf_empty),
    .count_o     (buf_count)
  );

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: a RAM model, a table of directed transfers,
// hand-written reset sequences and randomized transfers against a queue model.
module tb_ram_stream_reader;
  import ram_stream_reader_pkg::*;

  localparam int DW = 7;
  localparam int AW = 9;
  localparam int RAM_WORDS = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          start_i = 1'b0;
  logic [AW-1:0] base_addr_i = '0;
  logic [AW:0]   length_i = '0;
  logic [AW-1:0] read_addr_o;
  logic [DW-1:0] ram_q;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          ready_i = 1'b0;
  logic          last_o;
  logic          busy_o;
  logic          done_o;
  state_t        state_o;

  logic [DW-1:0] ram_mem [RAM_WORDS];
  logic [DW:0]   exp_q [$];
  int            vectors = 0;
  int            miscompares = 0;

  typedef struct {
    int base;
    int len;
    int ready_pct;
    int stall;
    int restart_at;
    bit check_lat;
    int exp_first;
  } vec_t;

  vec_t tbl [7];

  // clock / reset
  always #5 clk = ~clk;

  always @(posedge clk) ram_q <= ram_mem[read_addr_o];

  ram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BUF_DEPTH(4)) dut (
    .clock_i     (clk),
    .reset_i     (reset_i),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .length_i    (length_i),
    .read_addr_o (read_addr_o),
    .ram_q_i     (ram_q),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .last_o      (last_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .state_o     (state_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  // Drives one transfer from an IDLE negedge and scores every beat against
  // the words the RAM holds at base..base+len-1 (wrapping).
  task automatic run_transfer(input int base, input int len, input int ready_pct,
                              input int stall, input int restart_at,
                              input bit check_lat, input int exp_first);
    int n, first_v, last_pop_n, stall_left;
    bit seen_done, prev_vr;
    logic [DW:0] prev_beat, exp_b;
    exp_q.delete();
    for (int i = 0; i < len; i++)
      exp_q.push_back({(i == len - 1), ram_mem[(base + i) % RAM_WORDS]});
    start_i = 1'b1;
    base_addr_i = AW'(base);
    length_i = (AW+1)'(len);
    @(negedge clk);
    n = 0; first_v = -1; last_pop_n = -1; stall_left = stall;
    seen_done = 1'b0; prev_vr = 1'b0; prev_beat = '0;
    while (!seen_done && n < 2000) begin
      start_i = (n == restart_at);
      if (n == restart_at) begin
        base_addr_i = AW'(100);
        length_i = (AW+1)'(9);
      end
      if (n == 0) check("busy_after_start", 32'(busy_o), 1);
      if (valid_o && first_v < 0) begin
        first_v = n;
        if (exp_first >= 0) check("first_data", 32'(data_o), exp_first);
      end
      if (prev_vr) begin
        check("hold_valid", 32'(valid_o), 1);
        check("hold_beat", 32'({last_o, data_o}), 32'(prev_beat));
      end
      if (done_o) begin
        seen_done = 1'b1;
        check("done_cycle", n, (len == 0) ? 0 : last_pop_n + 1);
        check("beats_missing", exp_q.size(), 0);
      end
      if (first_v >= 0 && stall_left > 0) begin
        ready_i = 1'b0;
        stall_left--;
      end else begin
        ready_i = ($urandom_range(0, 99) < ready_pct);
      end
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) check("extra_beat", 1, 0);
        else begin
          exp_b = exp_q.pop_front();
          check("beat", 32'({last_o, data_o}), 32'(exp_b));
        end
        last_pop_n = n;
      end
      prev_vr = valid_o && !ready_i;
      prev_beat = {last_o, data_o};
      @(negedge clk);
      n++;
    end
    start_i = 1'b0;
    if (!seen_done) check("done_timeout", 0, 1);
    check("done_one_pulse", 32'(done_o), 0);
    check("idle_after_done", 32'(busy_o), 0);
    if (len > 0) check("read_addr_end", 32'(read_addr_o), (base + len - 1) % RAM_WORDS);
    if (check_lat && len > 0) begin
      check("first_valid_latency", first_v, 3);
      check("no_bubbles", last_pop_n - first_v, len - 1);
    end
  endtask

  initial begin
    for (int a = 0; a < RAM_WORDS; a++) ram_mem[a] = DW'(a % 128);

    tbl[0] = '{base: 0,   len: 5,   ready_pct: 100, stall: 0, restart_at: -1, check_lat: 1, exp_first: 0};
    tbl[1] = '{base: 510, len: 4,   ready_pct: 100, stall: 0, restart_at: -1, check_lat: 1, exp_first: 126};
    tbl[2] = '{base: 0,   len: 3,   ready_pct: 100, stall: 6, restart_at: -1, check_lat: 0, exp_first: 0};
    tbl[3] = '{base: 0,   len: 0,   ready_pct: 100, stall: 0, restart_at: -1, check_lat: 0, exp_first: -1};
    tbl[4] = '{base: 0,   len: 12,  ready_pct: 100, stall: 0, restart_at: 2,  check_lat: 1, exp_first: 0};
    tbl[5] = '{base: 300, len: 512, ready_pct: 100, stall: 0, restart_at: -1, check_lat: 1, exp_first: 44};
    tbl[6] = '{base: 5,   len: 30,  ready_pct: 60,  stall: 0, restart_at: -1, check_lat: 0, exp_first: 5};

    repeat (2) @(negedge clk);
    check("reset_valid", 32'(valid_o), 0);
    check("reset_busy", 32'(busy_o), 0);
    check("reset_done", 32'(done_o), 0);
    check("reset_last", 32'(last_o), 0);
    check("reset_data", 32'(data_o), 0);
    check("reset_addr", 32'(read_addr_o), 0);
    check("reset_state", 32'(state_o), 32'(ST_IDLE));
    reset_i = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 7; t++)
      run_transfer(tbl[t].base, tbl[t].len, tbl[t].ready_pct, tbl[t].stall,
                   tbl[t].restart_at, tbl[t].check_lat, tbl[t].exp_first);

    // asynchronous reset in the middle of a transfer
    start_i = 1'b1; base_addr_i = '0; length_i = (AW+1)'(20); ready_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_reset_valid", 32'(valid_o), 1);
    #2 reset_i = 1'b1;
    #1;
    check("async_reset_valid", 32'(valid_o), 0);
    check("async_reset_busy", 32'(busy_o), 0);
    check("async_reset_addr", 32'(read_addr_o), 0);
    @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    run_transfer(7, 2, 100, 0, -1, 1, 7);

    // randomized contents and transfers
    for (int a = 0; a < RAM_WORDS; a++) ram_mem[a] = DW'($urandom);
    for (int t = 0; t < 20; t++)
      run_transfer($urandom_range(0, RAM_WORDS - 1), $urandom_range(0, 40),
                   $urandom_range(40, 100), 0,
                   ($urandom_range(0, 1) == 1) ? $urandom_range(1, 10) : -1, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
